// File: rtl/timer_arbiter.sv
// Round-robin owner of a single shared timer, with a watchdog that frees the timer if PULSE never comes back.
// Latency is 2 cycles from REQ to TMR_START and 1 cycle from TMR_PULSE to DONE; each requester queues one request while the timer is busy.
module timer_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WD_MAX = 2097152
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GRANT,
    output logic [N_REQ-1:0] DONE,
    output logic             BUSY,
    output logic             ERR,
    output logic             TMR_START,
    input  logic             TMR_PULSE
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(WD_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_REQ);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t           state;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] pend_clr;
    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   sum;
    logic             win_vld;
    logic [WD_W-1:0]  wd;

    // Scan from farthest to nearest so the candidate right after 'last' is the one that sticks.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last;
        sum     = '0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = {1'b0, last} + (IDX_W + 1)'(k);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            cand = sum[IDX_W-1:0];
            if (pend[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign pend_clr = (state == S_IDLE && win_vld) ? win_oh : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            pend      <= '0;
            last      <= LAST_RST;
            wd        <= '0;
            GRANT     <= '0;
            DONE      <= '0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
            TMR_START <= 1'b0;
        end else begin
            DONE      <= '0;
            TMR_START <= 1'b0;
            // A request arriving on its own grant edge survives the clear.
            pend      <= (pend & ~pend_clr) | REQ;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        GRANT     <= win_oh;
                        last      <= win_idx;
                        TMR_START <= 1'b1;
                        BUSY      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wd <= wd + 1'b1;
                    if (TMR_PULSE) begin
                        DONE  <= GRANT;
                        GRANT <= '0;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else if (wd == WD_LAST) begin
                        ERR   <= 1'b1;
                        GRANT <= '0;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    a_grant_onehot0: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(GRANT));
    a_start_owned:   assert property (@(posedge CLK) disable iff (!RST_N) TMR_START |-> $onehot(GRANT));
    a_done_one:      assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(DONE));

endmodule
